pixel_ram_write_arbiter: RTL and testbench

- Shares the single write port of the dual-port pixel/iteration RAM among N_REQ Mandelbrot compute cores using round-robin arbitration.
- Provides a clear sequencer that sweeps every RAM address with CLEAR_VALUE before a new frame is rendered.
- Sits between the compute-core array and the RAM write port. The RAM read port (scan-out) does not pass through this block.

---
 rtl/pixel_ram_pkg.sv | 20 ++
 rtl/pixel_ram_write_arbiter_round_robin_grant.sv | 36 +++
 rtl/pixel_ram_write_arbiter.sv | 124 ++++++++++++
 tb/tb_pixel_ram_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ram_pkg.sv
// Shared definitions for the pixel/iteration RAM and the blocks that write it.
package pixel_ram_pkg;

  // Default geometry of the pixel/iteration RAM.
  localparam int PIXEL_DATA_WIDTH = 32;
  localparam int PIXEL_ADDR_WIDTH = 8;

  // Clear sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } clear_state_t;

  // True when a sweep counter holds the final address of the RAM.
  function automatic logic is_last_addr(input logic [PIXEL_ADDR_WIDTH-1:0] addr);
    return &addr;
  endfunction

endpackage

// File: rtl/pixel_ram_write_arbiter_round_robin_grant.sv
// Combinational round-robin grant: the search starts just after last_grant
// and wraps modulo N_REQ. Reusable by any shared-resource arbiter.
module round_robin_grant #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] request,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             grant_valid
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    int cand;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = int'(last_grant) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (request[IDX_W'(cand)]) begin
        grant                = '0;
        grant[IDX_W'(cand)]  = 1'b1;
        grant_index          = IDX_W'(cand);
        grant_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_ram_write_arbiter.sv
// Shares the pixel RAM write port among N_REQ compute cores (round robin)
// and sweeps the whole RAM with CLEAR_VALUE on request.
module pixel_ram_write_arbiter
  import pixel_ram_pkg::*;
#(
  parameter int                    N_REQ       = 4,
  parameter int                    DATA_WIDTH  = PIXEL_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = PIXEL_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        ram_wr_enable,
  output logic [ADDR_WIDTH-1:0]       ram_wr_addr,
  output logic [DATA_WIDTH-1:0]       ram_wr_data
);

  localparam int IDX_W = $clog2(N_REQ);

  clear_state_t          state_reg;
  logic [IDX_W-1:0]      last_grant_reg;
  logic [ADDR_WIDTH-1:0] counter_reg;
  logic                  wr_enable_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic                  clear_done_reg;

  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      grant_index;
  logic                  grant_valid;
  logic                  transfer;

  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  // Unpack the flat request buses into per-requester lanes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  round_robin_grant #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_grant (
    .request     (req_valid),
    .last_grant  (last_grant_reg),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // Grants are only visible while idle; the sweep owns the port otherwise.
  assign req_ready = (state_reg == S_IDLE) ? grant : '0;
  assign transfer  = (state_reg == S_IDLE) && grant_valid;

  assign clear_busy    = (state_reg != S_IDLE);
  assign clear_done    = clear_done_reg;
  assign ram_wr_enable = wr_enable_reg;
  assign ram_wr_addr   = wr_addr_reg;
  assign ram_wr_data   = wr_data_reg;

  // Clear FSM, grant history and the registered RAM write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      counter_reg    <= '0;
      wr_enable_reg  <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      clear_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          clear_done_reg <= 1'b0;
          // A grant issued alongside clear_start still completes; the sweep
          // overwrites it afterwards.
          if (transfer) begin
            wr_enable_reg  <= 1'b1;
            wr_addr_reg    <= addr_arr[grant_index];
            wr_data_reg    <= data_arr[grant_index];
            last_grant_reg <= grant_index;
          end else begin
            wr_enable_reg <= 1'b0;
          end
          if (clear_start) begin
            state_reg   <= S_CLEAR;
            counter_reg <= '0;
          end
        end
        S_CLEAR: begin
          wr_enable_reg <= 1'b1;
          wr_addr_reg   <= counter_reg;
          wr_data_reg   <= CLEAR_VALUE;
          counter_reg   <= counter_reg + 1'b1;
          // Stop on the all-ones address so every word is written once.
          if (&counter_reg) begin
            state_reg      <= S_DONE;
            clear_done_reg <= 1'b1;
          end
        end
        S_DONE: begin
          wr_enable_reg  <= 1'b0;
          clear_done_reg <= 1'b0;
          state_reg      <= S_IDLE;
        end
        default: begin
          wr_enable_reg  <= 1'b0;
          clear_done_reg <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_ram_write_arbiter.sv
// Directed bench for pixel_ram_write_arbiter: a vector table for arbitration
// and the write pipeline, then hand sequences for the clear sweep, a clear
// colliding with a grant, and a reset in the middle of a sweep.
module tb_pixel_ram_write_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        ram_wr_enable;
  logic [7:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;

  int checks;
  int failures;

  logic [31:0] mem [256];
  int          wr_count;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [17];

  pixel_ram_write_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .ram_wr_enable (ram_wr_enable),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model fed by the write port, plus a count of writes.
  always @(posedge clock) begin
    if (!reset && ram_wr_enable) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count         <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int snap;
    int nonzero;
    bit found;
    checks      = 0;
    failures    = 0;
    wr_count    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    reset       = 1'b1;
    req_valid   = 4'b0000;
    clear_start = 1'b0;
    // Requester lanes: r3, r2, r1, r0.
    req_addr = {8'h33, 8'h12, 8'h05, 8'h10};
    req_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h5555_5555, 32'h1111_0000};

    // Row k's write fields are the result of row k-1's transfer.
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 32'h0000_0000};
    vecs[1]  = '{4'b1111, 4'b0001, 1'b0, 8'h00, 32'h0000_0000};
    vecs[2]  = '{4'b1111, 4'b0010, 1'b1, 8'h10, 32'h1111_0000};
    vecs[3]  = '{4'b1111, 4'b0100, 1'b1, 8'h05, 32'h5555_5555};
    vecs[4]  = '{4'b1111, 4'b1000, 1'b1, 8'h12, 32'hDEAD_BEEF};
    vecs[5]  = '{4'b1111, 4'b0001, 1'b1, 8'h33, 32'h3333_3333};
    vecs[6]  = '{4'b1111, 4'b0010, 1'b1, 8'h10, 32'h1111_0000};
    vecs[7]  = '{4'b1111, 4'b0100, 1'b1, 8'h05, 32'h5555_5555};
    vecs[8]  = '{4'b1111, 4'b1000, 1'b1, 8'h12, 32'hDEAD_BEEF};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 8'h33, 32'h3333_3333};
    vecs[10] = '{4'b0100, 4'b0100, 1'b0, 8'h33, 32'h3333_3333};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 8'h12, 32'hDEAD_BEEF};
    vecs[12] = '{4'b1001, 4'b1000, 1'b0, 8'h12, 32'hDEAD_BEEF};
    vecs[13] = '{4'b1011, 4'b0001, 1'b1, 8'h33, 32'h3333_3333};
    vecs[14] = '{4'b1010, 4'b0010, 1'b1, 8'h10, 32'h1111_0000};
    vecs[15] = '{4'b0000, 4'b0000, 1'b1, 8'h05, 32'h5555_5555};
    vecs[16] = '{4'b0000, 4'b0000, 1'b0, 8'h05, 32'h5555_5555};

    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Vector table: arbitration order and the one-cycle write pipeline.
    for (int k = 0; k < 17; k++) begin
      next_cycle();
      req_valid = vecs[k].valid;
      @(negedge clock);
      $display("vec %0d valid=%b ready=%b wen=%b addr=%h data=%h", k, req_valid,
               req_ready, ram_wr_enable, ram_wr_addr, ram_wr_data);
      check($sformatf("vec%0d_ready", k), 64'(req_ready), 64'(vecs[k].ready));
      check($sformatf("vec%0d_wen", k), 64'(ram_wr_enable), 64'(vecs[k].wen));
      check($sformatf("vec%0d_addr", k), 64'(ram_wr_addr), 64'(vecs[k].addr));
      check($sformatf("vec%0d_data", k), 64'(ram_wr_data), 64'(vecs[k].data));
      check($sformatf("vec%0d_busy", k), 64'(clear_busy), 64'(0));
    end

    // Clear colliding with a grant to requester 1 (last grant was 1, so
    // requester 1 alone wins again).
    next_cycle();
    req_valid   = 4'b0010;
    clear_start = 1'b1;
    @(negedge clock);
    $display("clear_start with req1: ready=%b busy=%b", req_ready, clear_busy);
    check("collide_ready", 64'(req_ready), 64'(4'b0010));

    next_cycle();
    req_valid   = 4'b1111;
    clear_start = 1'b0;
    @(negedge clock);
    $display("collide write: wen=%b addr=%h data=%h busy=%b", ram_wr_enable,
             ram_wr_addr, ram_wr_data, clear_busy);
    check("collide_write", {ram_wr_enable, ram_wr_addr, ram_wr_data, req_ready, clear_busy, clear_done},
          {1'b1, 8'h05, 32'h5555_5555, 4'b0000, 1'b1, 1'b0});

    // Sweep: 256 consecutive writes of zero, done flag on the last one.
    for (int c = 1; c <= 256; c++) begin
      next_cycle();
      clear_start = (c == 10);
      @(negedge clock);
      $display("sweep %0d wen=%b addr=%h data=%h ready=%b busy=%b done=%b", c,
               ram_wr_enable, ram_wr_addr, ram_wr_data, req_ready, clear_busy, clear_done);
      check($sformatf("sweep%0d", c),
            {ram_wr_enable, ram_wr_addr, ram_wr_data, req_ready, clear_busy, clear_done},
            {1'b1, 8'(c - 1), 32'h0, 4'b0000, 1'b1, (c == 256)});
    end

    next_cycle();
    req_valid   = 4'b0000;
    clear_start = 1'b0;
    @(negedge clock);
    $display("after sweep: wen=%b busy=%b done=%b", ram_wr_enable, clear_busy, clear_done);
    check("post_sweep", {ram_wr_enable, ram_wr_addr, clear_busy, clear_done},
          {1'b0, 8'hFF, 1'b0, 1'b0});

    // A clear_start seen during the sweep must not launch another one.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clock);
      check($sformatf("not_queued%0d", c), {clear_busy, ram_wr_enable}, {1'b0, 1'b0});
    end

    nonzero = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== 32'h0) nonzero++;
    $display("readback: nonzero words=%0d mem[05]=%h", nonzero, mem[8'h05]);
    check("readback_nonzero", 64'(nonzero), 64'(0));
    check("readback_05", 64'(mem[8'h05]), 64'(32'h0));

    // Reset in the middle of a sweep, while address 0x40 is on the port.
    next_cycle();
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clock);
      if (ram_wr_enable && ram_wr_addr == 8'h40) found = 1'b1;
      else next_cycle();
    end
    check("sweep_reaches_40", 64'(found), 64'(1));
    reset = 1'b1;
    #1;
    $display("async reset: wen=%b addr=%h data=%h busy=%b", ram_wr_enable,
             ram_wr_addr, ram_wr_data, clear_busy);
    check("rst_outputs", {ram_wr_enable, ram_wr_addr, ram_wr_data, clear_busy, clear_done, req_ready},
          {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 4'b0000});
    next_cycle();
    next_cycle();
    reset = 1'b0;
    snap  = wr_count;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clock);
      check($sformatf("rst_idle%0d", c), {ram_wr_enable, clear_busy}, {1'b0, 1'b0});
    end
    check("rst_no_write", 64'(wr_count), 64'(snap));

    next_cycle();
    req_valid = 4'b0001;
    @(negedge clock);
    $display("post-reset grant: ready=%b", req_ready);
    check("rst_grant0", 64'(req_ready), 64'(4'b0001));
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clock);
    $display("post-reset write: wen=%b addr=%h data=%h", ram_wr_enable, ram_wr_addr, ram_wr_data);
    check("rst_write0", {ram_wr_enable, ram_wr_addr, ram_wr_data}, {1'b1, 8'h10, 32'h1111_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
